// File: rtl/riscv_mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mult_seq_pkg
// Shared types for the iterative multiplier/MAC:
//   mseq_op_t    - operation select (low half, high half, low half of a*b+c)
//   mseq_state_t - sequencer state
//   cnt_width()  - width of a chunk index counter (at least one bit)
//   norm_op()    - maps the unused operator encoding onto MSEQ_MUL
// -----------------------------------------------------------------------------
package riscv_mult_seq_pkg;

  typedef enum logic [1:0] {
    MSEQ_MUL  = 2'd0,
    MSEQ_MULH = 2'd1,
    MSEQ_MAC  = 2'd2
  } mseq_op_t;

  typedef enum logic [1:0] {
    MSEQ_IDLE = 2'd0,
    MSEQ_BUSY = 2'd1,
    MSEQ_DONE = 2'd2
  } mseq_state_t;

  function automatic int unsigned cnt_width(input int unsigned nc);
    return (nc > 1) ? $clog2(nc) : 1;
  endfunction

  // Encoding 3 has no operation of its own and behaves as a plain MUL.
  function automatic mseq_op_t norm_op(input logic [1:0] op);
    case (op)
      2'd1:    return MSEQ_MULH;
      2'd2:    return MSEQ_MAC;
      default: return MSEQ_MUL;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mult_seq_pp.sv
// -----------------------------------------------------------------------------
// riscv_mult_seq_pp
// Combinational chunk multiplier. Each CHUNK-bit slice is widened by one bit:
// the slice MSB when the caller marks the slice as the signed top chunk of its
// operand, zero otherwise. The two (CHUNK+1)-bit values are multiplied signed.
// Ports:
//   a_i, b_i        in   CHUNK      operand slices
//   a_sext_i        in   1          a slice is the top chunk of a signed operand
//   b_sext_i        in   1          b slice is the top chunk of a signed operand
//   pp_o            out  2*CHUNK+2  signed partial product
// -----------------------------------------------------------------------------
module riscv_mult_seq_pp
  import riscv_mult_seq_pkg::*;
#(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0]          a_i,
  input  logic [CHUNK-1:0]          b_i,
  input  logic                      a_sext_i,
  input  logic                      b_sext_i,
  output logic signed [2*CHUNK+1:0] pp_o
);

  logic signed [CHUNK:0] a_ext;
  logic signed [CHUNK:0] b_ext;

  assign a_ext = $signed({a_sext_i & a_i[CHUNK-1], a_i});
  assign b_ext = $signed({b_sext_i & b_i[CHUNK-1], b_i});

  // Widen both factors first so the product is formed at full result width.
  assign pp_o = (2*CHUNK+2)'(a_ext) * (2*CHUNK+2)'(b_ext);

endmodule

// File: rtl/riscv_mult_seq.sv
// -----------------------------------------------------------------------------
// riscv_mult_seq
// Iterative WIDTH x WIDTH multiplier / MAC. One CHUNK x CHUNK partial product
// per cycle is added into a 2*WIDTH accumulator, walking chunk pairs (i,j)
// i-major, j ascending. Low-half operations skip pairs with i+j >= NC because
// those only land above bit WIDTH-1.
// Ports:
//   clk          in   1      clock
//   rst          in   1      synchronous reset, active-high (beats flush_i)
//   flush_i      in   1      abort the operation in flight, discard results
//   in_valid_i   in   1      request
//   in_ready_o   out  1      idle, request can be accepted
//   operator_i   in   2      MSEQ_MUL / MSEQ_MULH / MSEQ_MAC
//   signed_i     in   2      bit0: op_a signed, bit1: op_b signed
//   op_a_i       in   WIDTH  multiplicand
//   op_b_i       in   WIDTH  multiplier
//   op_c_i       in   WIDTH  addend for MSEQ_MAC
//   out_valid_o  out  1      result available (held until out_ready_i)
//   out_ready_i  in   1      consumer takes the result
//   result_o     out  WIDTH  registered result
//   busy_o       out  1      operation in flight or result pending
// -----------------------------------------------------------------------------
module riscv_mult_seq
  import riscv_mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  mseq_op_t         operator_i,
  input  logic [1:0]       signed_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic [WIDTH-1:0] op_c_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int unsigned NC = WIDTH / CHUNK;
  localparam int unsigned CW = cnt_width(NC);
  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned SW = $clog2(AW);
  localparam logic [CW-1:0] LAST_IDX = CW'(NC - 1);

  mseq_state_t      state_q, state_d;
  mseq_op_t         op_q, op_d;
  logic [1:0]       sgn_q, sgn_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    i_q, i_d;
  logic [CW-1:0]    j_q, j_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [CHUNK-1:0]          a_chunk, b_chunk;
  logic signed [2*CHUNK+1:0] pp;
  logic [AW-1:0]             pp_ext;
  logic [SW-1:0]             shamt;
  logic [AW-1:0]             acc_step;
  logic                      op_hi;
  logic                      row_end;

  // ---------------------------------------------------------------------------
  // Datapath: current chunk pair -> shifted partial product -> accumulator sum
  // ---------------------------------------------------------------------------
  assign a_chunk = a_q[32'(i_q) * CHUNK +: CHUNK];
  assign b_chunk = b_q[32'(j_q) * CHUNK +: CHUNK];

  riscv_mult_seq_pp #(
    .CHUNK (CHUNK)
  ) u_pp (
    .a_i      (a_chunk),
    .b_i      (b_chunk),
    .a_sext_i (sgn_q[0] & (i_q == LAST_IDX)),
    .b_sext_i (sgn_q[1] & (j_q == LAST_IDX)),
    .pp_o     (pp)
  );

  // Signed cast sign-extends for NC>1; for NC=1 it truncates, which is still
  // exact because the accumulator wraps modulo 2^(2*WIDTH).
  assign pp_ext   = AW'(pp);
  assign shamt    = SW'((32'(i_q) + 32'(j_q)) * CHUNK);
  assign acc_step = acc_q + (pp_ext << shamt);

  assign op_hi = (op_q == MSEQ_MULH);
  // Last j of the current row: full row for MULH, triangle (i+j = NC-1) else.
  assign row_end = op_hi ? (j_q == LAST_IDX)
                         : ((32'(i_q) + 32'(j_q)) == (NC - 1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every _d gets its hold value first, so no path through the case
  // statement leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sgn_d    = sgn_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    i_d      = i_q;
    j_d      = j_q;
    result_d = result_q;

    case (state_q)
      MSEQ_IDLE: begin
        if (in_valid_i) begin
          state_d = MSEQ_BUSY;
          op_d    = norm_op(operator_i);
          sgn_d   = signed_i;
          a_d     = op_a_i;
          b_d     = op_b_i;
          acc_d   = (norm_op(operator_i) == MSEQ_MAC) ? {{WIDTH{1'b0}}, op_c_i}
                                                       : '0;
          i_d     = '0;
          j_d     = '0;
        end
      end

      MSEQ_BUSY: begin
        acc_d = acc_step;
        if (row_end) begin
          j_d = '0;
          if (i_q == LAST_IDX) begin
            state_d  = MSEQ_DONE;
            i_d      = '0;
            result_d = op_hi ? acc_step[AW-1:WIDTH] : acc_step[WIDTH-1:0];
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end

      MSEQ_DONE: begin
        if (out_ready_i) state_d = MSEQ_IDLE;
      end

      default: state_d = MSEQ_IDLE;
    endcase

    // Flush overrides any transition; a finished result is dropped as well.
    if (flush_i) begin
      state_d  = MSEQ_IDLE;
      acc_d    = '0;
      i_d      = '0;
      j_d      = '0;
      result_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments only, so every register samples the values
  // from before this edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: operand registers are reset along with the control state so a
      // reset unit holds no stale operand data; there is no memory array here.
      state_q  <= MSEQ_IDLE;
      op_q     <= MSEQ_MUL;
      sgn_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sgn_q    <= sgn_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      i_q      <= i_d;
      j_q      <= j_d;
      result_q <= result_d;
    end
  end

  assign in_ready_o  = (state_q == MSEQ_IDLE);
  assign out_valid_o = (state_q == MSEQ_DONE);
  assign busy_o      = (state_q != MSEQ_IDLE);
  assign result_o    = result_q;

endmodule

// File: tb/tb_riscv_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_riscv_mult_seq
// Two instances: WIDTH=32 and WIDTH=64 (CHUNK=16). 'sel' routes the request to
// one of them; control inputs are shared. A monitor keeps a scoreboard of the
// expected result and its due cycle, computed with plain 128-bit arithmetic,
// and checks the selected instance every cycle. Directed operations also pin
// result and latency against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_riscv_mult_seq;
  import riscv_mult_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [1:0]  op_s;
  logic [1:0]  sgn_s;
  logic [63:0] op_a, op_b, op_c;
  bit          sel;

  logic        rdy32, val32, busy32;
  logic [31:0] res32;
  logic        rdy64, val64, busy64;
  logic [63:0] res64;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  riscv_mult_seq #(.WIDTH(32), .CHUNK(16)) u_dut32 (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid & ~sel),
    .in_ready_o  (rdy32),
    .operator_i  (mseq_op_t'(op_s)),
    .signed_i    (sgn_s),
    .op_a_i      (op_a[31:0]),
    .op_b_i      (op_b[31:0]),
    .op_c_i      (op_c[31:0]),
    .out_valid_o (val32),
    .out_ready_i (out_ready),
    .result_o    (res32),
    .busy_o      (busy32)
  );

  riscv_mult_seq #(.WIDTH(64), .CHUNK(16)) u_dut64 (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid & sel),
    .in_ready_o  (rdy64),
    .operator_i  (mseq_op_t'(op_s)),
    .signed_i    (sgn_s),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .op_c_i      (op_c),
    .out_valid_o (val64),
    .out_ready_i (out_ready),
    .result_o    (res64),
    .busy_o      (busy64)
  );

  wire        cur_ready  = sel ? rdy64  : rdy32;
  wire        cur_valid  = sel ? val64  : val32;
  wire        cur_busy   = sel ? busy64 : busy32;
  wire [63:0] cur_result = sel ? res64  : {32'h0, res32};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact product of the two operands as integers, then pick half.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [1:0] sg,
                                        input logic [63:0] a, input logic [63:0] b,
                                        input logic [63:0] c, input int w);
    logic [127:0] m, sa, sb, p;
    m  = (w == 64) ? {64'h0, {64{1'b1}}} : {96'h0, 32'hFFFF_FFFF};
    sa = {64'h0, a} & m;
    sb = {64'h0, b} & m;
    if (sg[0] && a[w-1]) sa = sa | ~m;
    if (sg[1] && b[w-1]) sb = sb | ~m;
    p = sa * sb;
    if (op == 2'd1)      p = p >> w;
    else if (op == 2'd2) p = p + ({64'h0, c} & m);
    return 64'(p & m);
  endfunction

  function automatic int steps(input logic [1:0] op, input int w);
    int nc;
    nc = w / 16;
    return (op == 2'd1) ? nc * nc : nc * (nc + 1) / 2;
  endfunction

  // ---------------------------------------------------------------------------
  // Per-cycle monitor
  // ---------------------------------------------------------------------------
  bit          pending    = 1'b0;
  bit          known_zero = 1'b0;
  int          due;
  logic [63:0] exp_res;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pending) begin
        check("mon_in_ready", cur_ready, 0);
        check("mon_busy", cur_busy, 1);
        if (cyc < due) begin
          check("mon_early_valid", cur_valid, 0);
        end else begin
          check("mon_valid", cur_valid, 1);
          check("mon_result", cur_result, exp_res);
        end
      end else begin
        check("mon_idle_ready", cur_ready, 1);
        check("mon_idle_valid", cur_valid, 0);
        check("mon_idle_busy", cur_busy, 0);
        if (known_zero) check("mon_idle_result", cur_result, 0);
      end

      if (rst || flush) begin
        pending    = 1'b0;
        known_zero = 1'b1;
      end else if (pending && cyc >= due && out_ready) begin
        pending    = 1'b0;
        known_zero = 1'b0;
      end else if (!pending && in_valid) begin
        pending = 1'b1;
        exp_res = model(op_s, sgn_s, op_a, op_b, op_c, sel ? 64 : 32);
        due     = cyc + steps(op_s, sel ? 64 : 32) + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Returns at cycle 1 of the accepted operation (request already dropped).
  task automatic start_op(input bit s, input logic [1:0] op, input logic [1:0] sg,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    bit got;
    @(posedge clk); #1;
    sel = s; op_s = op; sgn_s = sg; op_a = a; op_b = b; op_c = c;
    in_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cur_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency in cycles from the handshake cycle to the first out_valid_o cycle.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (cur_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check("valid_timeout", 0, 1);
  endtask

  task automatic run_op(input bit s, input logic [1:0] op, input logic [1:0] sg,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input bit lit, input logic [63:0] exp_r, input int exp_lat,
                        input string name);
    int lat;
    start_op(s, op, sg, a, b, c);
    wait_valid(lat);
    if (lit) begin
      check({name, "_result"}, cur_result, exp_r);
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check({name, "_valid"}, cur_valid, 0);
    check({name, "_ready"}, cur_ready, 1);
    check({name, "_busy"}, cur_busy, 0);
    check({name, "_result"}, cur_result, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_s = 2'd0; sgn_s = 2'd0; op_a = '0; op_b = '0; op_c = '0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_idle("reset32");
    sel = 1'b1;
    check_idle("reset64");
    sel = 1'b0;

    // 32-bit directed operations
    run_op(0, 2'd1, 2'b11, 64'h8000_0000, 64'h8000_0000, 0, 1, 64'h4000_0000, 5, "mulh_ss_min");
    run_op(0, 2'd1, 2'b00, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 1, 64'hFFFF_FFFE, 5, "mulh_uu_max");
    run_op(0, 2'd0, 2'b00, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 1, 64'h0000_0001, 4, "mul_uu_max");
    run_op(0, 2'd1, 2'b01, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 1, 64'hFFFF_FFFF, 5, "mulh_su");
    run_op(0, 2'd2, 2'b00, 64'd3, 64'd5, 64'd10, 1, 64'h19, 4, "mac_small");
    run_op(0, 2'd1, 2'b10, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 0, 1, 64'hFFFF_FFFE, 5, "mulh_us");
    run_op(0, 2'd3, 2'b00, 64'd7, 64'd6, 0, 1, 64'h2A, 4, "op3_as_mul");
    run_op(0, 2'd2, 2'b11, 64'hFFFF_FFFE, 64'd3, 64'h10, 1, 64'hA, 4, "mac_signed");

    // Backpressure: result held, new request waits for the bubble cycle
    out_ready = 1'b0;
    run_op(0, 2'd0, 2'b00, 64'h1234, 64'h10, 0, 1, 64'h12340, 4, "bp_first");
    op_s = 2'd0; sgn_s = 2'b00; op_a = 64'd3; op_b = 64'd4; op_c = '0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_valid", cur_valid, 1);
      check("bp_hold_result", cur_result, 64'h12340);
      check("bp_hold_ready", cur_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_take_ready", cur_ready, 0);
    @(negedge clk);
    check("bp_bubble_ready", cur_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_valid(lat);
    check("bp_second_result", cur_result, 64'd12);
    check("bp_second_latency", 64'(lat), 64'd4);
    @(posedge clk); #1;

    // Flush during BUSY step 2
    start_op(0, 2'd1, 2'b11, 64'h1234_5678, 64'h9ABC_DEF0, 0);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check_idle("flush_busy");
    repeat (6) begin
      @(negedge clk);
      check("flush_busy_no_valid", cur_valid, 0);
    end

    // Flush while a result waits in DONE
    out_ready = 1'b0;
    run_op(0, 2'd0, 2'b00, 64'd9, 64'd9, 0, 1, 64'd81, 4, "pre_flush_done");
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; out_ready = 1'b1;
    check_idle("flush_done");

    // Reset in the middle of BUSY
    start_op(0, 2'd1, 2'b00, 64'hDEAD_BEEF, 64'hCAFE_F00D, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_idle("rst_busy");

    // 64-bit directed operations
    run_op(1, 2'd1, 2'b11, {64{1'b1}}, {64{1'b1}}, 0, 1, 64'h0, 17, "w64_mulh_ss");
    run_op(1, 2'd0, 2'b00, 64'h1_0000_0000, 64'h1_0000_0000, 0, 1, 64'h0, 11, "w64_mul_2p64");
    run_op(1, 2'd1, 2'b00, {64{1'b1}}, {64{1'b1}}, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 17, "w64_mulh_uu");

    // Random sweep on both widths, checked by the monitor
    for (int n = 0; n < 24; n++) begin
      run_op(n[0], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             0, 0, 0, "rand");
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/riscv_mult_seq.md
Name: riscv_mult_seq

Overview:
- Parametrised iterative integer multiplier/MAC for the EX stage. It is the area-optimised successor of the fixed 16x16 short multiplier with its MULH step sequencer.
- Each cycle one CHUNK x CHUNK partial product is accumulated into a 2*WIDTH accumulator, so any WIDTH/CHUNK ratio is supported.
- Adds a valid/ready handshake on input and output, early termination for low-half operations, and flush.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 16, partial-product slice width; NC = WIDTH/CHUNK (NC=1 gives a single-step multiply).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush_i  in  1  abort the operation in flight
- in_valid_i  in  1  operation request
- in_ready_o  out  1  unit can accept a request
- operator_i  in  2  mseq_op_t: MSEQ_MUL (low half), MSEQ_MULH (high half), MSEQ_MAC (low half of a*b+c)
- signed_i  in  2  bit0 = op_a signed, bit1 = op_b signed
- op_a_i  in  WIDTH  multiplicand
- op_b_i  in  WIDTH  multiplier
- op_c_i  in  WIDTH  accumulator addend (MSEQ_MAC only)
- out_valid_o  out  1  result available
- out_ready_i  in  1  consumer takes the result
- result_o  out  WIDTH  result
- busy_o  out  1  high in BUSY or DONE (multicycle indication to the controller)

Behaviour:
- Reset (and flush_i): state IDLE; out_valid_o=0; busy_o=0; result_o=0; accumulator and counters cleared; in_ready_o=1.
- FSM IDLE -> BUSY on in_valid_i && in_ready_o. Operands, operator and signedness are latched at this point; input ports are ignored afterwards.
- Accumulator initial value on entering BUSY:
  - MSEQ_MAC: op_c zero-extended.
  - Otherwise: 0.
- BUSY: one step per cycle over chunk pairs (i,j), i indexing A chunks and j indexing B chunks, in order i-major, j ascending.
  - Partial product: signed (CHUNK+1)x(CHUNK+1).
  - Chunk extension bit = signed_i[x] & chunk MSB, only for the top chunk (index NC-1); all other chunks are zero-extended.
  - The product is sign-extended to 2*WIDTH, shifted left by (i+j)*CHUNK, and added modulo 2^(2*WIDTH).
- Low-half operations (MSEQ_MUL, MSEQ_MAC) skip pairs with i+j >= NC, since those pairs do not affect the low WIDTH bits. Step counts:
  - Low-half: N_LO = NC(NC+1)/2.
  - MSEQ_MULH: N_HI = NC^2.
- Timing:
  - Handshake in cycle 0; steps run in cycles 1..N.
  - State DONE and out_valid_o=1 from cycle N+1.
  - WIDTH=32, CHUNK=16: MULH 4 steps, MUL/MAC 3 steps.
- result_o is registered:
  - MSEQ_MULH: acc[2W-1:W].
  - Otherwise: acc[W-1:0].
- DONE: result_o and out_valid_o are held stable until out_ready_i. On the out_valid_o && out_ready_i cycle the FSM goes to IDLE, and out_valid_o is 0 the next cycle.
- in_ready_o is 1 only in IDLE; there is no accept in the same cycle a result is taken (one bubble).
- flush_i has priority over every transition in any state. Next cycle is IDLE with no out_valid_o; a result in DONE is discarded.
- rst has priority over flush_i.
- signed_i=2'b10 (a unsigned, b signed) is legal and computed generically.
- A request with in_valid_i while not in IDLE is not accepted and must be held by the requester.

Decomposition:
- riscv_defines gains mseq_op_t (2-bit enum: MSEQ_MUL=0, MSEQ_MULH=1, MSEQ_MAC=2; value 3 is treated as MSEQ_MUL) and the state enum {MSEQ_IDLE, MSEQ_BUSY, MSEQ_DONE}.
- Sub-module riscv_mult_seq_pp: combinational signed (CHUNK+1)x(CHUNK+1) chunk multiplier with the extension-bit logic. It is instantiated once.
- Step counters i and j are $clog2(NC) bits each, minimum 1 bit.

Test Plan:
- MULH, signed 11, a=0x80000000, b=0x80000000 -> out_valid_o in cycle 5, result 0x40000000.
- MULH, signed 00, a=b=0xFFFFFFFF -> 0xFFFFFFFE. MUL with the same operands -> 0x00000001, out_valid_o in cycle 4.
- MULH, signed 01, a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MAC with a=3, b=5, c=10 -> 0x00000019.
- Backpressure: out_ready_i low for 3 cycles in DONE -> result_o and out_valid_o stable, in_ready_o=0. A new in_valid_i is not accepted until the cycle after the output handshake.
- flush_i in BUSY step 2, and separately in DONE -> IDLE next cycle, out_valid_o never asserted. rst mid-BUSY -> all outputs at reset values next cycle.
- WIDTH=64, CHUNK=16: MULH signed 11, a=-1, b=-1 -> 0, 16 steps. MUL with a=0x1_0000_0000, b=0x1_0000_0000 -> 0, 10 steps. Also a random signed/unsigned sweep checked against a reference model.
